if_stage: RTL and testbench

Instruction fetch stage of the mini CPU. It owns the fetch PC, issues word fetches to instruction memory over a valid/ready request channel with in-order, variable-latency responses, and buffers returned instructions in a 2-entry queue. It drives the IF/ID pipeline register's `valid` and `flush` inputs. Redirects from execute steer the PC and squash every in-flight and buffered instruction.

---
 rtl/if_stage.sv | 143 ++++++++++++++
 tb/tb_if_stage.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// Instruction fetch stage: owns the fetch PC, issues credit-limited word fetches,
// tracks in-flight PCs and buffers returned instructions in a 2-entry queue.
module if_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_resp_valid,
   input  logic [31:0] imem_resp_data,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   input  logic        stall,
   output logic [31:0] out_instr,
   output logic [31:0] out_pc,
   output logic        out_valid,
   output logic        out_flush
);

   localparam logic MODE_RUN   = 1'b0;
   localparam logic MODE_DRAIN = 1'b1;

   logic [31:0] fetch_pc_q, fetch_pc_d;
   logic [1:0]  outst_q, outst_d;
   logic [1:0]  drop_q, drop_d;
   logic [1:0]  buf_cnt_q, buf_cnt_d;
   logic        buf_head_q, buf_head_d;
   logic        pcf_wr_q, pcf_wr_d;
   logic        pcf_rd_q, pcf_rd_d;

   logic [31:0] pcf_q [2];
   logic [31:0] ibuf_pc_q [2];
   logic [31:0] ibuf_instr_q [2];

   logic        mode;
   logic        pop;
   logic [2:0]  credit_sum;
   logic        accept;
   logic        resp;
   logic        keep;
   logic        buf_wr_idx;
   logic [31:0] resp_pc;
   logic        unused_rpc_lo;

   assign unused_rpc_lo = ^redirect_pc[1:0];

   assign mode = (drop_q != 2'd0) ? MODE_DRAIN : MODE_RUN;

   assign out_valid  = (buf_cnt_q != 2'd0) & ~redirect;
   assign pop        = out_valid & ~stall;

   // Credit counts every in-flight request against a buffer slot, so a
   // response can never arrive without somewhere to land.
   assign credit_sum = {1'b0, outst_q} + {1'b0, buf_cnt_q} - {2'b00, pop};
   assign imem_req_valid = ~reset & ~redirect & (credit_sum < 3'd2);
   assign imem_req_addr  = fetch_pc_q;
   assign accept         = imem_req_valid & imem_req_ready;

   // A response with nothing outstanding is a protocol error and is ignored.
   assign resp       = imem_resp_valid & (outst_q != 2'd0);
   assign resp_pc    = pcf_q[pcf_rd_q];
   assign keep       = resp & (mode == MODE_RUN) & ~redirect;
   assign buf_wr_idx = buf_head_q ^ buf_cnt_q[0];

   assign out_instr = (buf_cnt_q != 2'd0) ? ibuf_instr_q[buf_head_q] : 32'h0;
   assign out_pc    = (buf_cnt_q != 2'd0) ? ibuf_pc_q[buf_head_q]    : 32'h0;
   assign out_flush = redirect & ~reset;

   always_comb begin
      fetch_pc_d = fetch_pc_q;
      outst_d    = outst_q;
      drop_d     = drop_q;
      buf_cnt_d  = buf_cnt_q;
      buf_head_d = buf_head_q;
      pcf_wr_d   = pcf_wr_q;
      pcf_rd_d   = pcf_rd_q;

      if (accept) begin
         fetch_pc_d = fetch_pc_q + 32'd4;
         pcf_wr_d   = ~pcf_wr_q;
      end
      if (resp) begin
         pcf_rd_d = ~pcf_rd_q;
      end

      case ({accept, resp})
         2'b10:   outst_d = outst_q + 2'd1;
         2'b01:   outst_d = outst_q - 2'd1;
         default: outst_d = outst_q;
      endcase

      if (redirect) begin
         // Everything still in flight belongs to the old path, including a
         // response landing in this very cycle.
         fetch_pc_d = {redirect_pc[31:2], 2'b00};
         buf_cnt_d  = 2'd0;
         buf_head_d = 1'b0;
         drop_d     = outst_q - {1'b0, resp};
      end else begin
         if (resp && (mode == MODE_DRAIN)) begin
            drop_d = drop_q - 2'd1;
         end
         buf_cnt_d = buf_cnt_q + {1'b0, keep} - {1'b0, pop};
         if (pop) begin
            buf_head_d = ~buf_head_q;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fetch_pc_q <= RESET_PC;
         outst_q    <= 2'd0;
         drop_q     <= 2'd0;
         buf_cnt_q  <= 2'd0;
         buf_head_q <= 1'b0;
         pcf_wr_q   <= 1'b0;
         pcf_rd_q   <= 1'b0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         outst_q    <= outst_d;
         drop_q     <= drop_d;
         buf_cnt_q  <= buf_cnt_d;
         buf_head_q <= buf_head_d;
         pcf_wr_q   <= pcf_wr_d;
         pcf_rd_q   <= pcf_rd_d;
      end
   end

   // Payload storage needs no reset: occupancy counters gate every read.
   always_ff @(posedge clk) begin
      if (accept) begin
         pcf_q[pcf_wr_q] <= fetch_pc_q;
      end
      if (keep) begin
         ibuf_pc_q[buf_wr_idx]    <= resp_pc;
         ibuf_instr_q[buf_wr_idx] <= imem_resp_data;
      end
   end

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: in-order variable-latency memory model plus a scoreboard
// of expected head PCs checked by an independent monitor.
`timescale 1ns/1ps
module tb_if_stage;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        reset;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_resp_valid;
   logic [31:0] imem_resp_data;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        stall;
   logic [31:0] out_instr;
   logic [31:0] out_pc;
   logic        out_valid;
   logic        out_flush;

   typedef struct packed {
      logic [31:0] addr;
      int unsigned due;
   } mreq_t;

   mreq_t       mq[$];
   logic [31:0] exp_q[$];
   logic [31:0] exp_tail;
   int unsigned cyc = 0;
   int unsigned lat_min = 1;
   int unsigned lat_max = 1;
   bit          rand_ready = 1'b0;
   int          vectors = 0;
   int          miscompares = 0;
   int          pops = 0;

   always #5 clk = ~clk;

   if_stage #(.RESET_PC(RESET_PC)) dut (
      .clk(clk), .reset(reset),
      .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
      .imem_req_addr(imem_req_addr), .imem_resp_valid(imem_resp_valid),
      .imem_resp_data(imem_resp_data), .redirect(redirect),
      .redirect_pc(redirect_pc), .stall(stall), .out_instr(out_instr),
      .out_pc(out_pc), .out_valid(out_valid), .out_flush(out_flush)
   );

   function automatic logic [31:0] imem_word(input logic [31:0] a);
      return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %08h, expected %08h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Memory: in order, latency >= 1 cycle, responses never back-pressured.
   initial begin
      imem_req_ready  = 1'b0;
      imem_resp_valid = 1'b0;
      imem_resp_data  = 32'h0;
      forever begin
         @(negedge clk);
         if (!reset && mq.size() > 0 && mq[0].due <= cyc) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = imem_word(mq[0].addr);
         end else begin
            imem_resp_valid = 1'b0;
            imem_resp_data  = 32'h0;
         end
         imem_req_ready = rand_ready ? ($urandom_range(2, 0) != 0) : 1'b1;
         #1;
         if (reset) begin
            mq.delete();
         end else begin
            if (imem_resp_valid) void'(mq.pop_front());
            if (imem_req_valid && imem_req_ready)
               mq.push_back('{addr: imem_req_addr,
                              due: cyc + ((lat_min == lat_max) ? lat_min
                                          : $urandom_range(lat_max, lat_min))});
            chk("credit_outstanding_le2", 32'(mq.size() <= 2), 32'd1);
         end
         cyc++;
      end
   end

   // Monitor: every pop must present the next expected PC and its word.
   initial begin
      logic [31:0] e;
      forever begin
         @(negedge clk);
         #1;
         if (!reset && out_valid && !stall) begin
            if (exp_q.size() == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL sb_underflow: got pop of pc %08h, expected no pop", out_pc);
            end else begin
               e = exp_q.pop_front();
               chk("head_pc", out_pc, e);
               chk("head_instr", out_instr, imem_word(e));
               pops++;
            end
         end
      end
   end

   task automatic drive(input logic rd, input logic [31:0] rpc, input logic st);
      redirect    = rd;
      redirect_pc = rpc;
      stall       = st;
      if (rd) begin
         exp_q.delete();
         exp_tail = {rpc[31:2], 2'b00};
      end
      while (exp_q.size() < 8) begin
         exp_q.push_back(exp_tail);
         exp_tail = exp_tail + 32'd4;
      end
   endtask

   task automatic cycle(input logic rd, input logic [31:0] rpc, input logic st);
      @(negedge clk);
      drive(rd, rpc, st);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 32'h0, 1'b0);
   endtask

   task automatic apply_reset(input int n);
      @(negedge clk);
      reset = 1'b1;
      exp_q.delete();
      exp_tail = RESET_PC;
      drive(1'b0, 32'h0, 1'b0);
      #1;
      for (int i = 1; i < n; i++) cycle(1'b0, 32'h0, 1'b0);
   endtask

   task automatic release_reset();
      @(negedge clk);
      reset = 1'b0;
      drive(1'b0, 32'h0, 1'b0);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      bit found;
      int pops0;
      reset       = 1'b1;
      redirect    = 1'b0;
      redirect_pc = 32'h0;
      stall       = 1'b0;
      exp_tail    = RESET_PC;

      apply_reset(3);
      chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
      chk("rst_req_addr", imem_req_addr, RESET_PC);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_flush", 32'(out_flush), 32'd0);
      chk("rst_out_instr", out_instr, 32'h0);
      chk("rst_out_pc", out_pc, 32'h0);

      // Reset release with 1-cycle memory
      release_reset();
      chk("c0_req_valid", 32'(imem_req_valid), 32'd1);
      chk("c0_req_addr", imem_req_addr, 32'h0);
      chk("c0_out_valid", 32'(out_valid), 32'd0);
      cycle(1'b0, 32'h0, 1'b0);
      chk("c1_req_addr", imem_req_addr, 32'h4);
      chk("c1_out_valid", 32'(out_valid), 32'd0);
      cycle(1'b0, 32'h0, 1'b0);
      chk("c2_req_addr", imem_req_addr, 32'h8);
      chk("c2_out_valid", 32'(out_valid), 32'd1);
      chk("c2_out_pc", out_pc, 32'h0);
      idle(8);

      // Stall for 5 cycles
      for (int i = 1; i <= 5; i++) cycle(1'b0, 32'h0, 1'b1);
      chk("stall_req_valid", 32'(imem_req_valid), 32'd0);
      chk("stall_out_valid", 32'(out_valid), 32'd1);
      chk("stall_head_pc", out_pc, exp_q[0]);
      idle(10);

      // Redirect with 2 outstanding, 3-cycle latency
      lat_min = 3;
      lat_max = 3;
      idle(10);
      found = 1'b0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (mq.size() == 2) begin
            found = 1'b1;
            break;
         end
         drive(1'b0, 32'h0, 1'b0);
         #1;
      end
      chk("redir_found_2_outstanding", 32'(found), 32'd1);
      if (!found) @(negedge clk);
      drive(1'b1, 32'h0000_0100, 1'b0);
      #1;
      chk("redir_flush", 32'(out_flush), 32'd1);
      chk("redir_out_valid", 32'(out_valid), 32'd0);
      chk("redir_req_valid", 32'(imem_req_valid), 32'd0);
      cycle(1'b0, 32'h0, 1'b0);
      chk("redir_flush_once", 32'(out_flush), 32'd0);
      chk("redir_new_addr", imem_req_addr, 32'h0000_0100);
      idle(15);

      // Redirect coincident with a response and with stall
      lat_min = 2;
      lat_max = 2;
      idle(8);
      found = 1'b0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (mq.size() > 0 && mq[0].due <= cyc) begin
            found = 1'b1;
            break;
         end
         drive(1'b0, 32'h0, 1'b0);
         #1;
      end
      chk("coinc_found_resp", 32'(found), 32'd1);
      if (!found) @(negedge clk);
      drive(1'b1, 32'h0000_0200, 1'b1);
      #1;
      chk("coinc_out_valid", 32'(out_valid), 32'd0);
      chk("coinc_flush", 32'(out_flush), 32'd1);
      chk("coinc_req_valid", 32'(imem_req_valid), 32'd0);
      cycle(1'b0, 32'h0, 1'b0);
      chk("coinc_new_addr", imem_req_addr, 32'h0000_0200);
      idle(15);

      // Misaligned target at the top of the address space wraps to 0
      lat_min = 1;
      lat_max = 1;
      idle(5);
      cycle(1'b1, 32'hFFFF_FFFE, 1'b0);
      found = 1'b0;
      for (int i = 0; i < 20; i++) begin
         cycle(1'b0, 32'h0, 1'b0);
         if (i == 0) chk("wrap_first_addr", imem_req_addr, 32'hFFFF_FFFC);
         if (imem_req_valid && imem_req_ready) begin
            found = 1'b1;
            break;
         end
      end
      chk("wrap_accepted", 32'(found), 32'd1);
      cycle(1'b0, 32'h0, 1'b0);
      chk("wrap_next_addr", imem_req_addr, 32'h0000_0000);
      idle(10);

      // Random ready, latency 1-4, redirects, stalls and one mid-run reset
      rand_ready = 1'b1;
      lat_min    = 1;
      lat_max    = 4;
      pops0      = pops;
      for (int i = 0; i < 600; i++) begin
         if (i == 300) begin
            apply_reset(2);
            chk("midrst_out_valid", 32'(out_valid), 32'd0);
            chk("midrst_req_valid", 32'(imem_req_valid), 32'd0);
            chk("midrst_out_flush", 32'(out_flush), 32'd0);
            release_reset();
            chk("midrst_restart_addr", imem_req_addr, RESET_PC);
         end else begin
            cycle(($urandom_range(15, 0) == 0), $urandom, ($urandom_range(3, 0) == 0));
         end
      end
      rand_ready = 1'b0;
      idle(20);
      chk("random_progress", 32'((pops - pops0) > 50), 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
